vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Parametrised, runtime-reprogrammable VGA/DVI timing generator replacing the fixed-width sync counter in the graphics path. Produces registered hsync/vsync with per-signal polarity, data-enable, pixel coordinates, line/frame start strobes and blanking flags. New timing sets are staged and committed atomically at a frame boundary, so the display never sees a torn frame. Feeds the framebuffer fetch unit and the VGA/DVI output pins.

Parameters:
HW, 12, horizontal counter/config width (bits)
VW, 11, vertical counter/config width (bits)
DEF_HACT, 640, reset horizontal active pixels
DEF_HFP, 16, reset horizontal front porch
DEF_HSYNC, 96, reset horizontal sync width
DEF_HBP, 48, reset horizontal back porch
DEF_VACT, 480, reset vertical active lines
DEF_VFP, 10, reset vertical front porch
DEF_VSYNC, 2, reset vertical sync width
DEF_VBP, 33, reset vertical back porch
DEF_HPOL, 0, reset hsync polarity (1 = active-high)
DEF_VPOL, 0, reset vsync polarity

Ports:
pixel_clk  in  1  pixel clock
rst  in  1  reset, synchronous, active-high
en  in  1  count enable; 0 freezes counters
cfg_load  in  1  one-cycle strobe; samples all cfg_* inputs into staging
cfg_hact, cfg_hfp, cfg_hsync, cfg_hbp  in  HW each  new horizontal timing
cfg_vact, cfg_vfp, cfg_vsync, cfg_vbp  in  VW each  new vertical timing
cfg_hpol, cfg_vpol  in  1 each  new sync polarities
cfg_pending  out  1  staged config awaiting frame boundary
cfg_applied  out  1  one-cycle pulse: staged config became active
cfg_err  out  1  one-cycle pulse: cfg_load rejected
hsync, vsync  out  1 each  sync outputs, polarity applied
de  out  1  active video (h and v both active)
hblank, vblank  out  1 each  outside active region, per axis
h_pos  out  HW  horizontal coordinate of current output pixel
v_pos  out  VW  vertical coordinate of current output line
line_start  out  1  pulse when h_pos==0
frame_start  out  1  pulse when h_pos==0 and v_pos==0

Behaviour:
- Active shadow set S; htot=hact+hfp+hsync+hbp, vtot likewise, computed in HW+1 / VW+1 bits.
- Internal hc counts 0..htot-1; at hc==htot-1: hc<=0, vc increments, vc wraps 0 after vtot-1. Region order per axis: active [0,act), FP, sync [act+fp, act+fp+sync), BP.
- All outputs registered: outputs reflect hc/vc of previous edge (latency 1). h_pos/v_pos equal that hc/vc; de/hblank/vblank/sync/strobes are coherent with h_pos/v_pos.
- hsync = hpol when in h-sync region else ~hpol; same for vsync. Sync width 0 yields no pulse.
- Reset: hc=0, vc=0, S=DEF_* values, staging cleared, cfg_pending=0. Outputs on reset cycle: de=0, hblank=vblank=1, line_start=frame_start=0, cfg_applied=cfg_err=0, h_pos=v_pos=0, hsync=~DEF_HPOL, vsync=~DEF_VPOL. First post-reset edge with en=1 presents pixel (0,0) with frame_start=1.
- en=0: hc/vc hold; de, line_start, frame_start forced 0; sync levels and h_pos/v_pos hold. cfg_load still accepted.
- cfg_load validation: reject (cfg_err=1 next cycle, staging unchanged) if act==0 on either axis, or htot > 2^HW-1 or vtot > 2^VW-1. Otherwise staging <= cfg_*, cfg_pending<=1.
- cfg_load while pending: overwrites staging; pending stays 1.
- Commit: on the edge where hc==htot-1, vc==vtot-1, en=1 and pending=1 (pending set before that edge): S<=staging, hc<=0, vc<=0, pending<=0. cfg_applied pulses on the same output cycle as the new frame's frame_start; that frame uses new timing including polarity.
- cfg_load on the commit edge itself: not committed this boundary; lands in staging, pending=1, applied at next boundary.
- rst mid-frame or with pending: all discarded, back to DEF_*.

Test Plan:
- Reset, en=1, defaults -> line period 800 clocks, frame 525 lines; hsync low for h_pos 656..751; vsync low for v_pos 490..491; de high exactly 640x480 per frame.
- Single frame_start every 420000 clocks; line_start every 800; first frame_start on first cycle after rst release.
- cfg_load mid-frame with 800x600 (40/128/88, 1/4/23, pol=1) -> cfg_pending=1 until boundary; next frame htot=1056, vtot=628, syncs active-high, cfg_applied coincident with frame_start.
- cfg_load with cfg_hact=0, and separately hact=4000,hfp=100 (sum>4095) -> cfg_err pulse, cfg_pending unchanged, timing unchanged.
- cfg_load asserted on exact commit edge -> current boundary keeps old timing; new set applied one frame later.
- en=0 for 50 cycles mid-line -> h_pos frozen, de=0, no strobes; resume continues from frozen h_pos+1; rst asserted with pending config -> defaults restored, cfg_pending=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Runtime-reprogrammable VGA/DVI timing generator with registered syncs, data enable,
// coordinates and strobes. New timing sets are staged and swapped in at a frame boundary.
module vga_timing_gen #(
    parameter int HW        = 12,
    parameter int VW        = 11,
    parameter int DEF_HACT  = 640,
    parameter int DEF_HFP   = 16,
    parameter int DEF_HSYNC = 96,
    parameter int DEF_HBP   = 48,
    parameter int DEF_VACT  = 480,
    parameter int DEF_VFP   = 10,
    parameter int DEF_VSYNC = 2,
    parameter int DEF_VBP   = 33,
    parameter int DEF_HPOL  = 0,
    parameter int DEF_VPOL  = 0
) (
    input  logic          pixel_clk,
    input  logic          rst,
    input  logic          en,
    input  logic          cfg_load,
    input  logic [HW-1:0] cfg_hact,
    input  logic [HW-1:0] cfg_hfp,
    input  logic [HW-1:0] cfg_hsync,
    input  logic [HW-1:0] cfg_hbp,
    input  logic [VW-1:0] cfg_vact,
    input  logic [VW-1:0] cfg_vfp,
    input  logic [VW-1:0] cfg_vsync,
    input  logic [VW-1:0] cfg_vbp,
    input  logic          cfg_hpol,
    input  logic          cfg_vpol,
    output logic          cfg_pending,
    output logic          cfg_applied,
    output logic          cfg_err,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          hblank,
    output logic          vblank,
    output logic [HW-1:0] h_pos,
    output logic [VW-1:0] v_pos,
    output logic          line_start,
    output logic          frame_start
);

    localparam logic [HW+1:0] H_MAX = (HW+2)'((1 << HW) - 1);
    localparam logic [VW+1:0] V_MAX = (VW+2)'((1 << VW) - 1);
    localparam logic [HW:0]   H_ONE = (HW+1)'(1);
    localparam logic [VW:0]   V_ONE = (VW+1)'(1);

    logic [HW-1:0] hact_s, hfp_s, hsync_s, hbp_s;
    logic [VW-1:0] vact_s, vfp_s, vsync_s, vbp_s;
    logic          hpol_s, vpol_s;

    logic [HW-1:0] hact_st, hfp_st, hsync_st, hbp_st;
    logic [VW-1:0] vact_st, vfp_st, vsync_st, vbp_st;
    logic          hpol_st, vpol_st;

    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic          apply_flag;

    logic [HW:0]   htot, hs_start, hs_end;
    logic [VW:0]   vtot, vs_start, vs_end;
    logic [HW+1:0] cfg_htot;
    logic [VW+1:0] cfg_vtot;
    logic          h_last, v_last, h_act, v_act, in_hsync, in_vsync, cfg_bad, commit;

    // Region boundaries of the active set; config totals use two extra bits so overflow is visible.
    always_comb begin
        htot     = {1'b0, hact_s} + {1'b0, hfp_s} + {1'b0, hsync_s} + {1'b0, hbp_s};
        vtot     = {1'b0, vact_s} + {1'b0, vfp_s} + {1'b0, vsync_s} + {1'b0, vbp_s};
        hs_start = {1'b0, hact_s} + {1'b0, hfp_s};
        hs_end   = hs_start + {1'b0, hsync_s};
        vs_start = {1'b0, vact_s} + {1'b0, vfp_s};
        vs_end   = vs_start + {1'b0, vsync_s};
        h_last   = ({1'b0, hc} == htot - H_ONE);
        v_last   = ({1'b0, vc} == vtot - V_ONE);
        h_act    = (hc < hact_s);
        v_act    = (vc < vact_s);
        in_hsync = ({1'b0, hc} >= hs_start) && ({1'b0, hc} < hs_end);
        in_vsync = ({1'b0, vc} >= vs_start) && ({1'b0, vc} < vs_end);
        cfg_htot = {2'b00, cfg_hact} + {2'b00, cfg_hfp} + {2'b00, cfg_hsync} + {2'b00, cfg_hbp};
        cfg_vtot = {2'b00, cfg_vact} + {2'b00, cfg_vfp} + {2'b00, cfg_vsync} + {2'b00, cfg_vbp};
        cfg_bad  = (cfg_hact == '0) || (cfg_vact == '0) || (cfg_htot > H_MAX) || (cfg_vtot > V_MAX);
        commit   = en && h_last && v_last && cfg_pending;
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            hc          <= '0;
            vc          <= '0;
            hact_s      <= HW'(DEF_HACT);
            hfp_s       <= HW'(DEF_HFP);
            hsync_s     <= HW'(DEF_HSYNC);
            hbp_s       <= HW'(DEF_HBP);
            vact_s      <= VW'(DEF_VACT);
            vfp_s       <= VW'(DEF_VFP);
            vsync_s     <= VW'(DEF_VSYNC);
            vbp_s       <= VW'(DEF_VBP);
            hpol_s      <= (DEF_HPOL != 0);
            vpol_s      <= (DEF_VPOL != 0);
            hact_st     <= '0;
            hfp_st      <= '0;
            hsync_st    <= '0;
            hbp_st      <= '0;
            vact_st     <= '0;
            vfp_st      <= '0;
            vsync_st    <= '0;
            vbp_st      <= '0;
            hpol_st     <= 1'b0;
            vpol_st     <= 1'b0;
            cfg_pending <= 1'b0;
            apply_flag  <= 1'b0;
            cfg_applied <= 1'b0;
            cfg_err     <= 1'b0;
            hsync       <= (DEF_HPOL == 0);
            vsync       <= (DEF_VPOL == 0);
            de          <= 1'b0;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            h_pos       <= '0;
            v_pos       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            cfg_err <= cfg_load && cfg_bad;
            if (en) begin
                h_pos       <= hc;
                v_pos       <= vc;
                de          <= h_act && v_act;
                hblank      <= !h_act;
                vblank      <= !v_act;
                hsync       <= in_hsync ? hpol_s : !hpol_s;
                vsync       <= in_vsync ? vpol_s : !vpol_s;
                line_start  <= (hc == '0);
                frame_start <= (hc == '0) && (vc == '0);
                cfg_applied <= apply_flag;
                apply_flag  <= 1'b0;
                if (h_last) begin
                    hc <= '0;
                    vc <= v_last ? '0 : vc + 1'b1;
                end else begin
                    hc <= hc + 1'b1;
                end
            end else begin
                de          <= 1'b0;
                line_start  <= 1'b0;
                frame_start <= 1'b0;
                cfg_applied <= 1'b0;
            end
            // The applied pulse is deferred until the new frame's first pixel is actually presented.
            if (commit) begin
                hact_s      <= hact_st;
                hfp_s       <= hfp_st;
                hsync_s     <= hsync_st;
                hbp_s       <= hbp_st;
                vact_s      <= vact_st;
                vfp_s       <= vfp_st;
                vsync_s     <= vsync_st;
                vbp_s       <= vbp_st;
                hpol_s      <= hpol_st;
                vpol_s      <= vpol_st;
                apply_flag  <= 1'b1;
                cfg_pending <= 1'b0;
            end
            // A load on the commit edge lands after the swap and waits for the next boundary.
            if (cfg_load && !cfg_bad) begin
                hact_st     <= cfg_hact;
                hfp_st      <= cfg_hfp;
                hsync_st    <= cfg_hsync;
                hbp_st      <= cfg_hbp;
                vact_st     <= cfg_vact;
                vfp_st      <= cfg_vfp;
                vsync_st    <= cfg_vsync;
                vbp_st      <= cfg_vbp;
                hpol_st     <= cfg_hpol;
                vpol_st     <= cfg_vpol;
                cfg_pending <= 1'b1;
            end
        end
    end

endmodule
